// File: rtl/instr_issue_if.sv
// Push and dispatch-lane bundle of the instruction issue unit.
// slave: the issue unit; master: the control unit side and the execution units.
interface instr_issue_if #(
   parameter int ADDR_W = 18
);
   logic              push_valid;
   logic              push_ready;
   logic [0:15]       push_instr;
   logic [3:0]        push_copies;
   logic [ADDR_W-1:0] push_cache_addr;
   logic [ADDR_W-1:0] push_main_addr;
   logic [ADDR_W-1:0] push_cache_stride;
   logic [ADDR_W-1:0] push_main_stride;

   logic              ldst_valid;
   logic              ldst_ready;
   logic [0:13]       ldst_instr;
   logic [ADDR_W-1:0] ldst_cache_addr;

   logic              ram_valid;
   logic              ram_ready;
   logic [0:6]        ram_instr;
   logic [ADDR_W-1:0] ram_cache_addr;
   logic [ADDR_W-1:0] ram_main_addr;

   logic              arith_valid;
   logic              arith_ready;
   logic [0:13]       arith_instr;

   modport slave (
      input  push_valid, push_instr, push_copies,
      input  push_cache_addr, push_main_addr,
      input  push_cache_stride, push_main_stride,
      output push_ready,
      output ldst_valid, ldst_instr, ldst_cache_addr,
      input  ldst_ready,
      output ram_valid, ram_instr, ram_cache_addr, ram_main_addr,
      input  ram_ready,
      output arith_valid, arith_instr,
      input  arith_ready
   );

   modport master (
      output push_valid, push_instr, push_copies,
      output push_cache_addr, push_main_addr,
      output push_cache_stride, push_main_stride,
      input  push_ready,
      input  ldst_valid, ldst_instr, ldst_cache_addr,
      output ldst_ready,
      input  ram_valid, ram_instr, ram_cache_addr, ram_main_addr,
      output ram_ready,
      input  arith_valid, arith_instr,
      output arith_ready
   );
endinterface

// File: rtl/instr_issue_unit.sv
// Instruction queue consumer: buffers entries, expands repeat copies and
// dispatches up to three distinct-unit instructions per issue group.
module instr_issue_unit #(
   parameter int LOG_DEPTH = 4,
   parameter int ADDR_W    = 18
) (
   input  logic             clk,
   input  logic             reset,
   instr_issue_if.slave     bus,
   output logic [LOG_DEPTH:0] count,
   output logic             empty,
   output logic             bad_instr
);
   localparam int DEPTH = 1 << LOG_DEPTH;

   typedef logic [LOG_DEPTH-1:0] ptr_t;
   typedef logic [LOG_DEPTH:0]   cnt_t;
   typedef logic [ADDR_W-1:0]    addr_t;
   typedef enum logic {IDLE, ISSUE} state_t;

   logic [0:15] q_instr [DEPTH];
   logic [3:0]  q_rem   [DEPTH];
   addr_t       q_cache [DEPTH];
   addr_t       q_main  [DEPTH];
   addr_t       q_cstr  [DEPTH];
   addr_t       q_mstr  [DEPTH];

   state_t     state;
   ptr_t       head;
   ptr_t       tail;
   logic [1:0] grp_n;

   ptr_t       slot_idx [3];
   logic [1:0] slot_ty  [3];
   logic [2:0] slot_on;

   logic       push_fire;
   logic       push_store;
   logic       retire;
   logic [1:0] pops;
   ptr_t       last;
   logic [2:0] lane_v;
   logic [2:0] lane_r;

   assign bus.push_ready = count < cnt_t'(DEPTH);
   assign empty          = count == '0;

   assign push_fire  = bus.push_valid && bus.push_ready;
   assign push_store = push_fire
                    && bus.push_instr[0:1] != 2'd3
                    && bus.push_copies != 4'd0;

   // A window grows only past final copies, into entries of unused types.
   always_comb begin
      for (int s = 0; s < 3; s++) begin
         slot_idx[s] = head + ptr_t'(s);
         slot_ty[s]  = q_instr[slot_idx[s]][0:1];
      end
      slot_on[0] = 1'b1;
      slot_on[1] = q_rem[slot_idx[0]] == 4'd1
                && count > cnt_t'(1)
                && slot_ty[1] != slot_ty[0];
      slot_on[2] = slot_on[1]
                && q_rem[slot_idx[1]] == 4'd1
                && count > cnt_t'(2)
                && slot_ty[2] != slot_ty[0]
                && slot_ty[2] != slot_ty[1];
   end

   assign lane_v = {bus.ldst_valid, bus.ram_valid, bus.arith_valid};
   assign lane_r = {bus.ldst_ready, bus.ram_ready, bus.arith_ready};
   assign retire = state == ISSUE && (lane_v & ~lane_r) == 3'b000;

   // Only the last slot of a group can have copies left.
   assign last = head + ptr_t'(grp_n) - ptr_t'(1);
   assign pops = grp_n - 2'd1 + {1'b0, q_rem[last] == 4'd1};

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         grp_n           <= '0;
         bad_instr       <= 1'b0;
         bus.ldst_valid  <= 1'b0;
         bus.ldst_instr  <= '0;
         bus.ldst_cache_addr <= '0;
         bus.ram_valid   <= 1'b0;
         bus.ram_instr   <= '0;
         bus.ram_cache_addr  <= '0;
         bus.ram_main_addr   <= '0;
         bus.arith_valid <= 1'b0;
         bus.arith_instr <= '0;
      end else begin
         if (push_fire && bus.push_instr[0:1] == 2'd3)
            bad_instr <= 1'b1;
         if (push_store)
            tail <= tail + ptr_t'(1);
         count <= count + cnt_t'(push_store)
                - (retire ? cnt_t'(pops) : cnt_t'(0));

         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  state <= ISSUE;
                  grp_n <= 2'd1 + 2'(slot_on[1]) + 2'(slot_on[2]);
                  for (int s = 0; s < 3; s++) begin
                     if (slot_on[s]) begin
                        unique case (1'b1)
                           slot_ty[s] == 2'd0: begin
                              bus.ldst_valid      <= 1'b1;
                              bus.ldst_instr      <= q_instr[slot_idx[s]][2:15];
                              bus.ldst_cache_addr <= q_cache[slot_idx[s]];
                           end
                           slot_ty[s] == 2'd1: begin
                              bus.ram_valid      <= 1'b1;
                              bus.ram_instr      <= q_instr[slot_idx[s]][2:8];
                              bus.ram_cache_addr <= q_cache[slot_idx[s]];
                              bus.ram_main_addr  <= q_main[slot_idx[s]];
                           end
                           default: begin
                              bus.arith_valid <= 1'b1;
                              bus.arith_instr <= q_instr[slot_idx[s]][2:15];
                           end
                        endcase
                     end
                  end
               end
            end
            ISSUE: begin
               if (bus.ldst_ready)
                  bus.ldst_valid <= 1'b0;
               if (bus.ram_ready)
                  bus.ram_valid <= 1'b0;
               if (bus.arith_ready)
                  bus.arith_valid <= 1'b0;
               if (retire) begin
                  head  <= head + ptr_t'(pops);
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // Entry storage; retire advances every entry of the group by one copy.
   always_ff @(posedge clk) begin
      if (!reset && push_store) begin
         q_instr[tail] <= bus.push_instr;
         q_rem[tail]   <= bus.push_copies;
         q_cache[tail] <= bus.push_cache_addr;
         q_main[tail]  <= bus.push_main_addr;
         q_cstr[tail]  <= bus.push_cache_stride;
         q_mstr[tail]  <= bus.push_main_stride;
      end
      if (!reset && retire) begin
         for (int s = 0; s < 3; s++) begin
            if (s < int'(grp_n)) begin
               q_rem[slot_idx[s]]   <= q_rem[slot_idx[s]] - 4'd1;
               q_cache[slot_idx[s]] <= q_cache[slot_idx[s]] + q_cstr[slot_idx[s]];
               q_main[slot_idx[s]]  <= q_main[slot_idx[s]] + q_mstr[slot_idx[s]];
            end
         end
      end
   end
endmodule
